// File: rtl/kernel_kcore_start_arbiter.sv
// Start arbiter that lets NUM_REQ start-token FIFOs share one HLS dataflow process.
// Latency: a pending token in ARB raises ap_start one cycle later; ap_done shows up as done_valid one cycle later.
// Backpressure: ap_start and grant_id hold until ap_ready. No new issue starts while MAX_OUTSTANDING invocations are in flight.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   req_empty_n/req_read  per-FIFO token flag in / one-hot pop strobe out
//   ap_start/ap_ready/ap_done  handshake with the shared process
//   grant_id          requester of the current or last issue
//   done_valid/done_id  completion pulse and the requester it belongs to
//   busy, err         activity flag; sticky flag for ap_done arriving with no invocation in flight
// Build option: KCORE_START_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module kernel_kcore_start_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int SEL_W           = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_empty_n,
  output logic [NUM_REQ-1:0] req_read,
  output logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  output logic [SEL_W-1:0]   grant_id,
  output logic               done_valid,
  output logic [SEL_W-1:0]   done_id,
  output logic               busy,
  output logic               err
);

  typedef enum logic {ARB = 1'b0, ISSUE = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     grant_q, grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]     id_q [MAX_OUTSTANDING];
  logic [SEL_W-1:0]     id_d [MAX_OUTSTANDING];
  logic                 done_valid_q, done_valid_d;
  logic [SEL_W-1:0]     done_id_q, done_id_d;
  logic                 err_q, err_d;
`ifndef KCORE_START_ARB_FIXED_PRIO_EN
  logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
`endif

  logic                 pop;
  logic                 issue;
  logic [CNT_W-1:0]     cnt_after_pop;
  logic                 found;
  logic [SEL_W-1:0]     winner;
  int                   search_start;
  int                   wr_idx;

  always_comb begin
    // The ID queue occupancy always equals the outstanding count, so cnt_q is also the queue fill level.
    pop           = ap_done && (cnt_q != '0);
    issue         = (state_q == ISSUE) && ap_ready;
    cnt_after_pop = cnt_q - CNT_W'(pop);

`ifdef KCORE_START_ARB_FIXED_PRIO_EN
    search_start = 0;
`else
    search_start = int'(rr_ptr_q);
`endif
    // Two passes replace a modulo walk: first indices at or above the pointer, then wrap from 0.
    found  = 1'b0;
    winner = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req_empty_n[j] && (j >= search_start)) begin
        found  = 1'b1;
        winner = SEL_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req_empty_n[j]) begin
        found  = 1'b1;
        winner = SEL_W'(j);
      end
    end

    state_d      = state_q;
    grant_d      = grant_q;
`ifndef KCORE_START_ARB_FIXED_PRIO_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    done_valid_d = pop;
    done_id_d    = pop ? id_q[0] : done_id_q;
    err_d        = err_q | (ap_done && (cnt_q == '0));
    cnt_d        = cnt_q + CNT_W'(issue) - CNT_W'(pop);

    unique case (state_q)
      ARB: begin
        // The limit uses the count after this cycle's completion, so a done frees a slot immediately.
        if (found && (cnt_after_pop < CNT_W'(MAX_OUTSTANDING))) begin
          state_d = ISSUE;
          grant_d = winner;
        end
      end
      ISSUE: begin
        if (ap_ready) begin
          state_d = ARB;
`ifndef KCORE_START_ARB_FIXED_PRIO_EN
          rr_ptr_d = (grant_q == SEL_W'(NUM_REQ - 1)) ? '0 : grant_q + SEL_W'(1);
`endif
        end
      end
      default: state_d = ARB;
    endcase

    // Shift-register queue: head is always slot 0, and a pop frees its slot before the push lands.
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      id_d[i] = id_q[i];
    end
    if (pop) begin
      for (int i = 0; i < MAX_OUTSTANDING - 1; i++) begin
        id_d[i] = id_q[i+1];
      end
    end
    wr_idx = int'(cnt_q) - (pop ? 1 : 0);
    if (issue) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (i == wr_idx) id_d[i] = grant_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ARB;
      grant_q      <= '0;
      cnt_q        <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      err_q        <= 1'b0;
`ifndef KCORE_START_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= '0;
`endif
      for (int i = 0; i < MAX_OUTSTANDING; i++) id_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      err_q        <= err_d;
`ifndef KCORE_START_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
      for (int i = 0; i < MAX_OUTSTANDING; i++) id_q[i] <= id_d[i];
    end
  end

  // The pop strobe is gated by reset so a reset landing on an accepted start never consumes a token.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_read[i] = reset && issue && (grant_q == SEL_W'(i));
    end
  end

  assign ap_start   = (state_q == ISSUE);
  assign grant_id   = grant_q;
  assign done_valid = done_valid_q;
  assign done_id    = done_id_q;
  assign busy       = (cnt_q != '0) || (state_q == ISSUE);
  assign err        = err_q;

endmodule

// File: tb/tb_kernel_kcore_start_arbiter.sv
module tb_kernel_kcore_start_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req_empty_n;
  logic [3:0] req_read;
  logic       ap_start;
  logic       ap_ready;
  logic       ap_done;
  logic [1:0] grant_id;
  logic       done_valid;
  logic [1:0] done_id;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;
  int exp_issue [$];
  int exp_done  [$];
  logic done_follow = 1'b0;

  kernel_kcore_start_arbiter #(
    .NUM_REQ(4), .SEL_W(2), .MAX_OUTSTANDING(2), .CNT_W(2)
  ) dut (
    .clk(clk), .reset(reset), .req_empty_n(req_empty_n), .req_read(req_read),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .grant_id(grant_id),
    .done_valid(done_valid), .done_id(done_id), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: every pop and every completion must match the next expected entry.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (req_read !== 4'b0000) begin
          if (exp_issue.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pop actual=%0h required=none at %0t", req_read, $time);
          end else begin
            e = exp_issue.pop_front();
            chk("issue_grant", 32'(grant_id), 32'(e));
            chk("issue_read", 32'(req_read), 32'(1) << e);
          end
        end
        if (done_valid !== 1'b0) begin
          if (exp_done.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done actual=%0h required=none at %0t", done_id, $time);
          end else begin
            e = exp_done.pop_front();
            chk("done_id", 32'(done_id), 32'(e));
          end
        end
      end
    end
  end

  // Optional responder: ap_done one cycle after each accepted start.
  initial begin
    logic s;
    forever begin
      @(negedge clk);
      s = (reset === 1'b1) && (req_read !== 4'b0000);
      @(posedge clk);
      #2;
      if (done_follow) ap_done = s;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; counts pops (including the current cycle) up to n, bounded.
  task automatic wait_pops(input int n);
    int seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (req_read !== 4'b0000) seen++;
      if (seen >= n) break;
      @(negedge clk);
    end
    chk("pop_count", 32'(seen), 32'(n));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    done_follow = 1'b0;
    ap_done     = 1'b0;
    ap_ready    = 1'b1;
    reset       = 1'b0;
    @(negedge clk);
    chk("rst_no_pop", 32'(req_read), 32'h0);
    chk("sb_issue_empty", 32'(exp_issue.size()), 32'h0);
    chk("sb_done_empty", 32'(exp_done.size()), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ap_start", 32'(ap_start), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    ap_ready = 1'b0;
    reset    = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    req_empty_n = 4'b1111;
    ap_ready    = 1'b0;
    ap_done     = 1'b0;

    // Reset with all FIFOs non-empty.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ap_start", 32'(ap_start), 32'h0);
    chk("reset_req_read", 32'(req_read), 32'h0);
    chk("reset_done_valid", 32'(done_valid), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_grant", 32'(grant_id), 32'h0);

    // Round-robin with ap_ready tied high, ready accepted on the first ap_start cycle.
    @(posedge clk); #1;
    reset       = 1'b1;
    ap_ready    = 1'b1;
    done_follow = 1'b1;
    exp_issue   = '{0, 1, 2, 3, 0};
    exp_done    = '{0, 1, 2, 3, 0};
    @(negedge clk);
    chk("release_ap_start_low", 32'(ap_start), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("release_ap_start", 32'(ap_start), 32'h1);
    chk("release_grant", 32'(grant_id), 32'h0);
    wait_pops(5);

    // Backpressure: grant 1 held for five cycles.
    @(posedge clk); #1;
    ap_ready = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ap_start", 32'(ap_start), 32'h1);
      chk("bp_grant", 32'(grant_id), 32'h1);
      chk("bp_req_read", 32'(req_read), 32'h0);
    end
    @(posedge clk); #1;
    ap_ready = 1'b1;
    exp_issue.push_back(1);
    exp_done.push_back(1);
    @(posedge clk); #1;
    ap_ready = 1'b0;
    @(negedge clk);
    chk("bp_start_drop", 32'(ap_start), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_grant", 32'(grant_id), 32'h2);
    chk("bp_busy", 32'(busy), 32'h1);
    repeat (3) @(posedge clk);
    do_reset();

    // Outstanding limit: two issues, then stall until a completion.
    ap_ready  = 1'b1;
    exp_issue = '{0, 1};
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("lim_ap_start", 32'(ap_start), 32'h0);
    chk("lim_busy", 32'(busy), 32'h1);
    @(posedge clk); #1;
    ap_done = 1'b1;
    exp_done.push_back(0);
    exp_issue.push_back(2);
    @(posedge clk); #1;
    ap_done = 1'b0;
    @(negedge clk);
    chk("lim_third_start", 32'(ap_start), 32'h1);
    chk("lim_third_grant", 32'(grant_id), 32'h2);
    @(posedge clk); #1;
    ap_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lim_stall_again", 32'(ap_start), 32'h0);

    // Completion frees a slot, then ready and done land in the same cycle.
    @(posedge clk); #1;
    ap_done = 1'b1;
    exp_done.push_back(1);
    @(posedge clk); #1;
    ap_ready = 1'b1;
    exp_issue.push_back(3);
    exp_done.push_back(2);
    @(posedge clk); #1;
    ap_done = 1'b0;
    exp_issue.push_back(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ap_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sim_full_stall", 32'(ap_start), 32'h0);
    chk("sim_busy", 32'(busy), 32'h1);
    @(posedge clk); #1;
    ap_done = 1'b1;
    exp_done.push_back(3);
    @(posedge clk); #1;
    ap_done = 1'b0;
    @(posedge clk); #1;
    ap_done = 1'b1;
    exp_done.push_back(0);
    @(posedge clk); #1;
    ap_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("drain_busy_issue", 32'(busy), 32'h1);
    chk("drain_err", 32'(err), 32'h0);
    do_reset();

    // Spurious completion while idle.
    req_empty_n = 4'b0000;
    @(posedge clk); #1;
    ap_done = 1'b1;
    @(posedge clk); #1;
    ap_done = 1'b0;
    @(negedge clk);
    chk("spur_err", 32'(err), 32'h1);
    chk("spur_done_valid", 32'(done_valid), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("spur_err_sticky", 32'(err), 32'h1);
    chk("spur_busy", 32'(busy), 32'h0);
    chk("spur_ap_start", 32'(ap_start), 32'h0);
    do_reset();

    // Two requesters set: alternation, or always index 1 with fixed priority.
    req_empty_n = 4'b1010;
    ap_ready    = 1'b1;
    done_follow = 1'b1;
`ifdef KCORE_START_ARB_FIXED_PRIO_EN
    exp_issue = '{1, 1, 1, 1};
    exp_done  = '{1, 1, 1, 1};
`else
    exp_issue = '{1, 3, 1, 3};
    exp_done  = '{1, 3, 1, 3};
`endif
    @(negedge clk);
    wait_pops(4);
    @(posedge clk); #1;
    ap_ready = 1'b0;
    repeat (4) @(posedge clk);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
